// File: rtl/placar_de_registradores_pkg.sv
// Shared definitions for the register-file scoreboard / write-port scheduler.
package placar_de_registradores_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam int NUM_REGS   = 32;
    localparam int ZERO_REG   = 0;
    localparam int CLEAR_LAST = 31;

endpackage

// File: rtl/placar_buffer_mdu.sv
// One-entry holding register for MDU results waiting for the write port.
module placar_buffer_mdu #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_rd,
    input  logic [DATA_W-1:0] load_data,
    input  logic              drain,
    output logic              in_ready,
    output logic              full,
    output logic [ADDR_W-1:0] buf_rd,
    output logic [DATA_W-1:0] buf_data
);

    logic              full_q, full_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Occupancy: a load only happens into an empty entry, so load and drain never collide.
    always_comb begin
        full_d = full_q;
        rd_d   = rd_q;
        data_d = data_q;
        if (load) begin
            full_d = 1'b1;
            rd_d   = load_rd;
            data_d = load_data;
        end else if (drain) begin
            full_d = 1'b0;
        end
    end

    // Occupancy flag is control and is reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
        end
    end

    // Payload is only meaningful while full, so it carries no reset.
    always_ff @(posedge clk) begin
        rd_q   <= rd_d;
        data_q <= data_d;
    end

    assign in_ready = !full_q;
    assign full     = full_q;
    assign buf_rd   = rd_q;
    assign buf_data = data_q;

endmodule

// File: rtl/placar_de_registradores.sv
// Register-file scoreboard and write-port scheduler.
// Clears all registers after reset, tracks pending writes, stalls decode on
// RAW/WAW hazards and arbitrates the write port between write-back and the MDU.
// Optional feature macro: PLACAR_STALL_COUNT_EN (stall-cycle counter).
module placar_de_registradores
    import placar_de_registradores_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 5,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                pr_in_clk,
    input  logic                pr_in_reset_n,
    input  logic                pr_in_issue_valid,
    input  logic [ADDR_W-1:0]   pr_in_issue_rs,
    input  logic [ADDR_W-1:0]   pr_in_issue_rt,
    input  logic [ADDR_W-1:0]   pr_in_issue_rd,
    input  logic                pr_in_issue_wr,
    output logic                pr_out_stall,
    input  logic                pr_in_wb_valid,
    input  logic [ADDR_W-1:0]   pr_in_wb_rd,
    input  logic [DATA_W-1:0]   pr_in_wb_data,
    input  logic                pr_in_mdu_valid,
    output logic                pr_out_mdu_ready,
    input  logic [ADDR_W-1:0]   pr_in_mdu_rd,
    input  logic [DATA_W-1:0]   pr_in_mdu_data,
    output logic                pr_out_we,
    output logic [ADDR_W-1:0]   pr_out_wa,
    output logic [DATA_W-1:0]   pr_out_wdata,
    output logic [NUM_REGS-1:0] pr_out_busy,
    output logic [31:0]         pr_out_stall_count
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR  = ADDR_W'(ZERO_REG);
    localparam logic [ADDR_W-1:0] CLEAR_ADDR = ADDR_W'(CLEAR_LAST);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;

    logic              run;
    logic              hazard;
    logic              issue_acc;
    logic              wb_acc;
    logic              buf_ready, buf_full, mdu_load, drain;
    logic [ADDR_W-1:0] buf_rd;
    logic [DATA_W-1:0] buf_data;

    assign run = (state_q == ST_RUN);

    placar_buffer_mdu #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_buffer_mdu (
        .clk       (pr_in_clk),
        .rst_n     (pr_in_reset_n),
        .load      (mdu_load),
        .load_rd   (pr_in_mdu_rd),
        .load_data (pr_in_mdu_data),
        .drain     (drain),
        .in_ready  (buf_ready),
        .full      (buf_full),
        .buf_rd    (buf_rd),
        .buf_data  (buf_data)
    );

    // Hazard detection, handshakes and scoreboard next state.
    always_comb begin
        hazard           = busy_q[pr_in_issue_rs] || busy_q[pr_in_issue_rt] ||
                           (pr_in_issue_wr && busy_q[pr_in_issue_rd]);
        pr_out_stall     = run ? (pr_in_issue_valid && hazard) : 1'b1;
        pr_out_mdu_ready = pr_in_reset_n && run && buf_ready;
        mdu_load         = pr_in_mdu_valid && pr_out_mdu_ready;
        drain            = run && !pr_in_wb_valid && buf_full;
        issue_acc        = run && pr_in_issue_valid && !pr_out_stall;
        wb_acc           = run && pr_in_wb_valid;

        // Retire first so that a same-cycle issue to the same register wins.
        busy_d = busy_q;
        if (wb_acc) begin
            busy_d[pr_in_wb_rd] = 1'b0;
        end
        if (drain) begin
            busy_d[buf_rd] = 1'b0;
        end
        if (issue_acc && pr_in_issue_wr && (pr_in_issue_rd != ZERO_ADDR)) begin
            busy_d[pr_in_issue_rd] = 1'b1;
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    // FSM next state: CLEAR walks every address once, then RUN.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == CLEAR_ADDR) begin
                state_d = ST_RUN;
            end
        end
    end

    // Write port: clear sequence, then write-back over the buffered MDU result.
    always_comb begin
        pr_out_we    = 1'b0;
        pr_out_wa    = '0;
        pr_out_wdata = '0;
        if (pr_in_reset_n) begin
            if (!run) begin
                pr_out_we = 1'b1;
                pr_out_wa = clr_cnt_q;
            end else if (pr_in_wb_valid) begin
                pr_out_we    = (pr_in_wb_rd != ZERO_ADDR);
                pr_out_wa    = pr_in_wb_rd;
                pr_out_wdata = pr_in_wb_data;
            end else if (buf_full) begin
                pr_out_we    = (buf_rd != ZERO_ADDR);
                pr_out_wa    = buf_rd;
                pr_out_wdata = buf_data;
            end
        end
    end

    // State, clear counter and scoreboard registers.
    always_ff @(posedge pr_in_clk or negedge pr_in_reset_n) begin
        if (!pr_in_reset_n) begin
            state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clr_cnt_q <= '0;
            busy_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            busy_q    <= busy_d;
        end
    end

    assign pr_out_busy = busy_q;

`ifdef PLACAR_STALL_COUNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of RUN cycles in which decode was held.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (run && pr_in_issue_valid && pr_out_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge pr_in_clk or negedge pr_in_reset_n) begin
        if (!pr_in_reset_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign pr_out_stall_count = stall_cnt_q;
`else
    assign pr_out_stall_count = '0;
`endif

endmodule

// File: doc/placar_de_registradores.md
# placar_de_registradores

- Scoreboard and write-port scheduler for the pipelined MIPS register file.
- After reset it sequences a clear of all 32 registers through the single write port.
- In normal operation it tracks pending destination writes, stalls decode on RAW/WAW hazards, and arbitrates the write port between the pipeline write-back stage and the multi-cycle multiply/divide unit (MDU).
- It sits between decode, write-back, the MDU and the register file write inputs.

## Interface
Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width (32 registers)
- CLEAR_ON_RESET, 1, 1 = run CLEAR sequence after reset; 0 = go straight to RUN

Ports:
- pr_in_clk  in  1  the single clock
- pr_in_reset_n  in  1  reset, asynchronous, active-low
- pr_in_issue_valid  in  1  decode presents an instruction
- pr_in_issue_rs  in  ADDR_W  source register 1
- pr_in_issue_rt  in  ADDR_W  source register 2
- pr_in_issue_rd  in  ADDR_W  destination register
- pr_in_issue_wr  in  1  instruction writes rd
- pr_out_stall  out  1  decode must hold; issue not accepted
- pr_in_wb_valid  in  1  pipeline write-back this cycle
- pr_in_wb_rd  in  ADDR_W  write-back address
- pr_in_wb_data  in  DATA_W  write-back data
- pr_in_mdu_valid  in  1  MDU result offered
- pr_out_mdu_ready  out  1  MDU result accepted when high with valid
- pr_in_mdu_rd  in  ADDR_W  MDU destination
- pr_in_mdu_data  in  DATA_W  MDU result
- pr_out_we  out  1  register file write enable
- pr_out_wa  out  ADDR_W  register file write address
- pr_out_wdata  out  DATA_W  register file write data
- pr_out_busy  out  32  scoreboard vector; bit n = write to reg n pending
- pr_out_stall_count  out  32  stall cycles (see Configuration)

## Operation
- FSM states: CLEAR, RUN.
- Reset enters CLEAR if CLEAR_ON_RESET=1, else RUN.
- CLEAR:
  - 5-bit counter 0..31; each cycle we=1, wa=counter, wdata=0.
  - stall=1, mdu_ready=0, write-back ignored.
  - After address 31 is written, go to RUN.
- RUN issue:
  - Issue is accepted when issue_valid && !stall.
  - If issue_wr && rd!=0, busy[rd] sets at the next edge.
- Stall (combinational, RUN):
  - stall = issue_valid && (busy[rs] || busy[rt] || (issue_wr && busy[rd])).
  - busy[0] is constant 0.
  - A register retiring in the current cycle still stalls; decode proceeds the next cycle.
- Retire:
  - An accepted wb or an MDU buffer drain clears busy[addr] at the next edge.
  - If an issue sets and a retire clears the same register in the same cycle, the set wins.
- Write port arbitration:
  - Pipeline write-back has absolute priority: wb_valid gives we=1, wa=wb_rd, wdata=wb_data.
  - MDU results go through a 1-entry buffer. mdu_ready = !buf_full.
  - mdu_valid && mdu_ready captures into the buffer.
  - The buffer drains onto the port in any RUN cycle with wb_valid=0.
  - A simultaneous capture and drain is not allowed: capture needs an empty buffer.
- Register 0: a write addressed to 0 drives we=0 but still retires normally.

## Timing
- Reset values:
  - stall=1 when CLEAR_ON_RESET=1, else 0.
  - we=0, wa=0, wdata=0, busy=0, mdu_ready=0, stall_count=0.
  - Buffer empty, counter 0.
- Reset asserted mid-operation: all state clears immediately and asynchronously; CLEAR restarts from address 0.
- CLEAR lasts exactly 32 cycles; the first RUN cycle is cycle 33 after reset release.
- we/wa/wdata are combinational from wb inputs or from the buffer register. The register file samples them on the same edge.
- MDU latency: accepted at edge N, written to the register file in the first cycle after N with wb_valid=0. mdu_ready rises the cycle after the drain.
- busy updates one edge after issue or retire; stall reflects registered busy.

## Configuration
- PLACAR_STALL_COUNT_EN defined:
  - pr_out_stall_count increments in each RUN cycle with issue_valid && stall.
  - Saturates at 0xFFFFFFFF.
- Not defined: the counter logic is absent and pr_out_stall_count is tied to 0.

## Structure
- Shared package holds:
  - FSM state encoding (CLEAR, RUN)
  - NUM_REGS=32
  - ZERO_REG=0
  - CLEAR_LAST=31
- One sub-module: placar_buffer_mdu, the 1-entry valid/ready holding register with a drain input.

## Test plan
- Reset release with CLEAR_ON_RESET=1:
  - we=1 and wa=0..31 with wdata=0 over 32 cycles, stall=1 throughout.
  - Cycle 33: stall=0 with issue_valid=0.
- RAW hazard:
  - Issue rd=8 wr=1, then the next cycle rs=8 → stall=1 until wb_valid rd=8 retires.
  - stall=0 the following cycle; busy[8]=0.
- Port conflict:
  - mdu_valid rd=9 data=0x1234 accepted; the next cycle wb_valid rd=10 data=0xAA → we wa=10 wdata=0xAA.
  - The cycle after: wa=9 wdata=0x1234; mdu_ready low until then.
- Register 0:
  - Issue rd=0 → busy stays 0.
  - wb_valid rd=0 → we=0.
  - Later issue with rs=0 → no stall.
- Same-cycle set/clear:
  - wb retiring rd=5 while a new issue has rd=5 → busy[5]=1 afterwards.
- With PLACAR_STALL_COUNT_EN: 3 stalled issue cycles → stall_count=3.
- Reset mid-run with busy=0x0000_0300 → busy=0 immediately, CLEAR restarts at wa=0.
